// File: rtl/booth_control_fsm.sv
// Control sequencer for the radix-2 Booth multiplier datapath: LOAD, then N x (CHECK, SHIFT), then DONE.
// Optional build macro BOOTH_ABORT_EN adds an abort input that cancels a running multiply.
module booth_control_fsm #(
   parameter int unsigned N = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
`ifdef BOOTH_ABORT_EN
   input  logic       abort,
`endif
   input  logic [1:0] Q_LSB,
   output logic       load_A,
   output logic       load_B,
   output logic       load_add,
   output logic       add_sub,
   output logic       shift_HQ_LQ_Q_1,
   output logic       busy,
   output logic       done,
   output logic       ready
);

   localparam int unsigned CNT_W = $clog2(N + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               r_ready;
   logic               w_ready_next;
   logic               w_abort;

`ifdef BOOTH_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign ready = r_ready;

   // State, iteration counter and ready flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
         r_ready <= w_ready_next;
      end
   end

   // Next-state and strobe decode; CHECK decodes the Booth pair {Q0, Q-1} combinationally
   always_comb begin
      w_next_state    = r_state;
      w_cnt_next      = r_cnt;
      w_ready_next    = r_ready;
      load_A          = 1'b0;
      load_B          = 1'b0;
      load_add        = 1'b0;
      add_sub         = 1'b0;
      shift_HQ_LQ_Q_1 = 1'b0;
      busy            = 1'b0;
      done            = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = LOAD;
               w_ready_next = 1'b0;
            end
         end
         LOAD: begin
            load_A       = 1'b1;
            load_B       = 1'b1;
            busy         = 1'b1;
            w_cnt_next   = CNT_W'(N);
            w_next_state = CHECK;
         end
         CHECK: begin
            busy = 1'b1;
            case (Q_LSB)
               2'b01:   load_add = 1'b1;
               2'b10: begin
                  load_add = 1'b1;
                  add_sub  = 1'b1;
               end
               default: load_add = 1'b0;
            endcase
            w_next_state = SHIFT;
         end
         SHIFT: begin
            busy            = 1'b1;
            shift_HQ_LQ_Q_1 = 1'b1;
            w_cnt_next      = r_cnt - CNT_W'(1);
            w_next_state    = (r_cnt == CNT_W'(1)) ? DONE : CHECK;
         end
         DONE: begin
            done         = 1'b1;
            w_ready_next = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase

      // Abort cancels the operation: strobes dropped this cycle, back to IDLE without done/ready
      if (w_abort && busy) begin
         load_A          = 1'b0;
         load_B          = 1'b0;
         load_add        = 1'b0;
         add_sub         = 1'b0;
         shift_HQ_LQ_Q_1 = 1'b0;
         w_cnt_next      = '0;
         w_next_state    = IDLE;
      end
   end

endmodule

// File: tb/tb_booth_control_fsm.sv
// Directed bench for booth_control_fsm: N=8 and N=4 instances, each driving a behavioural Booth datapath.
module tb_booth_control_fsm;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- N=8 instance and datapath ----------------
   logic       start8 = 1'b0;
   logic [1:0] q8;
   logic       la8, lb8, lad8, as8, sh8, busy8, done8, rdy8;
   logic [7:0] a8 = '0, b8 = '0, m8, hq8, lq8;
   logic       q1_8;

   booth_control_fsm #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8),
`ifdef BOOTH_ABORT_EN
      .abort(1'b0),
`endif
      .Q_LSB(q8), .load_A(la8), .load_B(lb8), .load_add(lad8), .add_sub(as8),
      .shift_HQ_LQ_Q_1(sh8), .busy(busy8), .done(done8), .ready(rdy8)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m8 <= '0; hq8 <= '0; lq8 <= '0; q1_8 <= 1'b0;
      end else begin
         if (la8) m8 <= a8;
         if (lb8) begin
            lq8 <= b8; hq8 <= '0; q1_8 <= 1'b0;
         end else if (lad8) begin
            hq8 <= as8 ? hq8 - m8 : hq8 + m8;
         end else if (sh8) begin
            hq8  <= {hq8[7], hq8[7:1]};
            lq8  <= {hq8[0], lq8[7:1]};
            q1_8 <= lq8[0];
         end
      end
   end
   assign q8 = {lq8[0], q1_8};

   // ---------------- N=4 instance and datapath ----------------
   logic       start4 = 1'b0;
   logic       abort4 = 1'b0;
   logic [1:0] q4;
   logic       la4, lb4, lad4, as4, sh4, busy4, done4, rdy4;
   logic [3:0] a4 = '0, b4 = '0, m4, hq4, lq4;
   logic       q1_4;

   booth_control_fsm #(.N(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4),
`ifdef BOOTH_ABORT_EN
      .abort(abort4),
`endif
      .Q_LSB(q4), .load_A(la4), .load_B(lb4), .load_add(lad4), .add_sub(as4),
      .shift_HQ_LQ_Q_1(sh4), .busy(busy4), .done(done4), .ready(rdy4)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m4 <= '0; hq4 <= '0; lq4 <= '0; q1_4 <= 1'b0;
      end else begin
         if (la4) m4 <= a4;
         if (lb4) begin
            lq4 <= b4; hq4 <= '0; q1_4 <= 1'b0;
         end else if (lad4) begin
            hq4 <= as4 ? hq4 - m4 : hq4 + m4;
         end else if (sh4) begin
            hq4  <= {hq4[3], hq4[3:1]};
            lq4  <= {hq4[0], lq4[3:1]};
            q1_4 <= lq4[0];
         end
      end
   end
   assign q4 = {lq4[0], q1_4};

   // ---------------- run statistics ----------------
   int          ld_cnt, ld_cyc, add_cnt, sub_cnt, first_sub, sh_cnt, busy_cnt;
   int          done_cnt, done_cyc, rdy_cyc, dec_bad, excl_bad;
   logic        rdy_at1;
   logic [15:0] y8;
   int          done4_cnt, done4_cyc, rdy4_cyc;
   logic [4:0]  strb_ab;
   logic        busy_after;
   logic [7:0]  y4;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One N=8 multiply from start edge (cycle 0) to cycle 22; extra start pulses in cycles p1..p3
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input int p1, input int p2, input int p3);
      ld_cnt = 0; ld_cyc = 0; add_cnt = 0; sub_cnt = 0; first_sub = 0; sh_cnt = 0;
      busy_cnt = 0; done_cnt = 0; done_cyc = 0; rdy_cyc = 0; dec_bad = 0; excl_bad = 0;
      a8 = a; b8 = b; start8 = 1'b1;
      step();
      start8 = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         if (c == 1) rdy_at1 = rdy8;
         if (la8 | lb8) begin ld_cnt++; ld_cyc = c; end
         if (lad8 && !as8) add_cnt++;
         if (lad8 && as8) begin
            sub_cnt++;
            if (first_sub == 0) first_sub = c;
         end
         if (sh8) sh_cnt++;
         if (busy8) busy_cnt++;
         if (done8) begin done_cnt++; done_cyc = c; end
         if (rdy8 && rdy_cyc == 0) rdy_cyc = c;
         if (busy8 && !la8 && !sh8 &&
             (lad8 !== (q8 == 2'b01 || q8 == 2'b10) || as8 !== (q8 == 2'b10))) dec_bad++;
         if (int'(la8 | lb8) + int'(lad8) + int'(sh8) > 1) excl_bad++;
         start8 = (c == p1) || (c == p2) || (c == p3);
         step();
      end
      start8 = 1'b0;
      y8 = {hq8, lq8};
   endtask

   // One N=4 multiply for cycles 1..14; abort held high during cycle ac (0 = none)
   task automatic run4(input logic [3:0] a, input logic [3:0] b, input int ac);
      done4_cnt = 0; done4_cyc = 0; rdy4_cyc = 0; strb_ab = '1; busy_after = 1'b1;
      a4 = a; b4 = b; start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         abort4 = (c == ac);
         #1;
         if (c == ac) strb_ab = {la4, lb4, lad4, as4, sh4};
         if (ac != 0 && c == ac + 1) busy_after = busy4;
         if (done4) begin done4_cnt++; done4_cyc = c; end
         if (rdy4 && rdy4_cyc == 0) rdy4_cyc = c;
         step();
      end
      abort4 = 1'b0;
      y4 = {hq4, lq4};
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) step();
      total++;
      if ({la8, lb8, lad8, as8, sh8, busy8, done8, rdy8} !== 8'h00) begin
         bad++; $display("FAIL reset8_outputs: got %b want 00000000",
                         {la8, lb8, lad8, as8, sh8, busy8, done8, rdy8});
      end
      total++;
      if ({la4, lb4, lad4, as4, sh4, busy4, done4, rdy4} !== 8'h00) begin
         bad++; $display("FAIL reset4_outputs: got %b want 00000000",
                         {la4, lb4, lad4, as4, sh4, busy4, done4, rdy4});
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) step();
      total++;
      if ({busy8, done8, rdy8} !== 3'b000) begin
         bad++; $display("FAIL idle_after_release: got %b want 000", {busy8, done8, rdy8});
      end
   endtask

   task automatic test_basic();
      run8(8'd3, 8'd5, 0, 0, 0);
      total++;
      if (ld_cnt !== 1 || ld_cyc !== 1) begin
         bad++; $display("FAIL basic_load: got cnt=%0d cyc=%0d want cnt=1 cyc=1", ld_cnt, ld_cyc);
      end
      total++;
      if (done_cnt !== 1 || done_cyc !== 18) begin
         bad++; $display("FAIL basic_done: got cnt=%0d cyc=%0d want cnt=1 cyc=18", done_cnt, done_cyc);
      end
      total++;
      if (rdy_cyc !== 19) begin
         bad++; $display("FAIL basic_ready: got first=%0d want 19", rdy_cyc);
      end
      total++;
      if (y8 !== 16'd15) begin
         bad++; $display("FAIL basic_product: got %h want 000f", y8);
      end
      total++;
      if (excl_bad !== 0 || dec_bad !== 0) begin
         bad++; $display("FAIL basic_strobes: got excl=%0d dec=%0d want 0 0", excl_bad, dec_bad);
      end
   endtask

   task automatic test_signed();
      run8(8'hFD, 8'd7, 0, 0, 0);
      total++;
      if (rdy_at1 !== 1'b0) begin
         bad++; $display("FAIL signed_ready_clear: got %b want 0", rdy_at1);
      end
      total++;
      if (sub_cnt !== 1 || add_cnt !== 1 || first_sub !== 2 || dec_bad !== 0) begin
         bad++; $display("FAIL signed_decode: got sub=%0d add=%0d first=%0d dec=%0d want 1 1 2 0",
                         sub_cnt, add_cnt, first_sub, dec_bad);
      end
      total++;
      if (y8 !== 16'hFFEB || done_cyc !== 18) begin
         bad++; $display("FAIL signed_product: got %h done=%0d want ffeb done=18", y8, done_cyc);
      end
   endtask

   task automatic test_operand_edges();
      run8(8'd9, 8'h00, 0, 0, 0);
      total++;
      if (add_cnt + sub_cnt !== 0 || sh_cnt !== 8 || y8 !== 16'h0000) begin
         bad++; $display("FAIL b_zero: got adds=%0d shifts=%0d y=%h want 0 8 0000",
                         add_cnt + sub_cnt, sh_cnt, y8);
      end
      run8(8'd5, 8'hFF, 0, 0, 0);
      total++;
      if (sub_cnt !== 1 || add_cnt !== 0 || first_sub !== 2 || sh_cnt !== 8) begin
         bad++; $display("FAIL b_minus1_ops: got sub=%0d add=%0d first=%0d shifts=%0d want 1 0 2 8",
                         sub_cnt, add_cnt, first_sub, sh_cnt);
      end
      total++;
      if (busy_cnt !== 17 || y8 !== 16'hFFFB) begin
         bad++; $display("FAIL b_minus1_result: got busy=%0d y=%h want 17 fffb", busy_cnt, y8);
      end
   endtask

   task automatic test_ignored_start();
      run8(8'd6, 8'd9, 5, 17, 18);
      total++;
      if (done_cnt !== 1 || done_cyc !== 18 || ld_cnt !== 1 || y8 !== 16'd54) begin
         bad++; $display("FAIL ignored_start: got done=%0d@%0d loads=%0d y=%h want 1@18 1 0036",
                         done_cnt, done_cyc, ld_cnt, y8);
      end
      total++;
      if (busy8 !== 1'b0 || rdy8 !== 1'b1) begin
         bad++; $display("FAIL ignored_start_idle: got busy=%b ready=%b want 0 1", busy8, rdy8);
      end
      start8 = 1'b1;
      #1;
      total++;
      if (rdy8 !== 1'b1) begin
         bad++; $display("FAIL ready_hold_before_edge: got %b want 1", rdy8);
      end
      step();
      start8 = 1'b0;
      total++;
      if (rdy8 !== 1'b0 || la8 !== 1'b1) begin
         bad++; $display("FAIL restart_clears_ready: got ready=%b load_A=%b want 0 1", rdy8, la8);
      end
      repeat (20) step();
   endtask

   task automatic test_reset_mid();
      a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
      step();
      start8 = 1'b0;
      repeat (8) step();
      total++;
      if (sh8 !== 1'b1) begin
         bad++; $display("FAIL mid_reset_in_shift: got shift=%b want 1", sh8);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if ({la8, lb8, lad8, as8, sh8, busy8, done8, rdy8} !== 8'h00) begin
         bad++; $display("FAIL mid_reset_outputs: got %b want 00000000",
                         {la8, lb8, lad8, as8, sh8, busy8, done8, rdy8});
      end
      #2 rst = 1'b1;
      step();
      run8(8'd4, 8'd4, 0, 0, 0);
      total++;
      if (done_cyc !== 18 || y8 !== 16'd16) begin
         bad++; $display("FAIL after_reset_run: got done=%0d y=%h want 18 0010", done_cyc, y8);
      end
   endtask

   task automatic test_n4();
      run4(4'd7, 4'hE, 0);
      total++;
      if (done4_cnt !== 1 || done4_cyc !== 10 || rdy4_cyc !== 11) begin
         bad++; $display("FAIL n4_timing: got done=%0d@%0d ready=%0d want 1@10 11",
                         done4_cnt, done4_cyc, rdy4_cyc);
      end
      total++;
      if (y4 !== 8'hF2) begin
         bad++; $display("FAIL n4_product: got %h want f2", y4);
      end
   endtask

`ifdef BOOTH_ABORT_EN
   task automatic test_abort();
      run4(4'd7, 4'h5, 6);
      total++;
      if (strb_ab !== 5'b00000) begin
         bad++; $display("FAIL abort_strobes: got %b want 00000", strb_ab);
      end
      total++;
      if (busy_after !== 1'b0 || done4_cnt !== 0 || rdy4_cyc !== 0 || rdy4 !== 1'b0) begin
         bad++; $display("FAIL abort_idle: got busy7=%b dones=%0d ready_first=%0d want 0 0 0",
                         busy_after, done4_cnt, rdy4_cyc);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_operand_edges();
      test_ignored_start();
      test_reset_mid();
      test_n4();
`ifdef BOOTH_ABORT_EN
      test_abort();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
